// File: rtl/jt7759_feeder.sv
// jt7759_feeder: streams a block of ROM bytes into a slave-mode ADPCM chip,
// one byte per drqn request, with a single-cycle cs/wrn strobe per byte.
// Build option: define JT7759_FEED_PREFETCH_EN to replace the single holding
// register with a DEPTH-entry prefetch FIFO filled independently of drqn.
module jt7759_feeder #(
    parameter int unsigned AW    = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    input  logic          drqn,
    output logic          cs,
    output logic          wrn,
    output logic [7:0]    dout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DRQ,
        WRITE,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;       // bytes still to be written
    logic [AW-1:0] fetch_q, fetch_d;   // bytes still to be fetched from ROM
    logic [AW-1:0] addr_q, addr_d;
    logic          stable_q, stable_d; // rom_addr was already requested last cycle
    logic [7:0]    dout_q, dout_d;
    logic          done_q, done_d;

    logic          start_acc;
    logic          go_write;
    logic          capture;
    logic          space;
    logic          avail;
    logic [7:0]    head;

    assign start_acc = start && !stop && (state_q == IDLE);
    assign rom_cs    = (state_q != IDLE) && (fetch_q != '0) && space;
    assign capture   = rom_cs && rom_ok && stable_q;
    assign go_write  = (state_q == WAIT_DRQ) && !drqn && avail && !stop;
    assign stable_d  = rom_cs && !capture;

`ifdef JT7759_FEED_PREFETCH_EN
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   fill_q;

    assign space = (fill_q != FULL);
    assign avail = (fill_q != '0);
    assign head  = mem_q[rd_q];

    // FIFO storage: written on every ROM capture
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_q] <= rom_data;
        end
    end

    // FIFO pointers and occupancy; stop discards whatever was prefetched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else if (stop) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            if (capture) begin
                wr_q <= wr_q + PW'(1);
            end
            if (go_write) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({capture, go_write})
                2'b10:   fill_q <= fill_q + (PW+1)'(1);
                2'b01:   fill_q <= fill_q - (PW+1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end
`else
    logic [7:0]  hold_q;
    logic        hold_vld_q;
    logic [31:0] unused_depth;

    assign unused_depth = DEPTH;
    assign space        = !hold_vld_q;
    assign avail        = hold_vld_q;
    assign head         = hold_q;

    // Single holding register; the next fetch may begin once the byte has
    // been handed to the write strobe, which is what keeps a 3-cycle pace
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (stop) begin
            hold_vld_q <= 1'b0;
        end else if (capture) begin
            hold_q     <= rom_data;
            hold_vld_q <= 1'b1;
        end else if (go_write) begin
            hold_vld_q <= 1'b0;
        end
    end
`endif

    // Next-state logic for the write engine and the fetch address/counters.
    // The drqn holdoff spans the strobe cycle (WRITE) and one HOLD cycle, so
    // drqn is next sampled in WAIT_DRQ and writes are at least 3 cycles apart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fetch_d = fetch_q;
        addr_d  = addr_q;
        dout_d  = '0;
        done_d  = 1'b0;

        if (capture) begin
            addr_d  = addr_q + AW'(1);
            fetch_d = fetch_q - AW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    addr_d  = start_addr;
                    cnt_d   = length;
                    fetch_d = length;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT_DRQ;
                    end
                end
            end
            WAIT_DRQ: begin
                if (go_write) begin
                    state_d = WRITE;
                    dout_d  = head;
                end
            end
            WRITE: begin
                cnt_d   = cnt_q - AW'(1);
                done_d  = (cnt_q == AW'(1));
                state_d = HOLD;
            end
            HOLD: begin
                state_d = (cnt_q == '0) ? IDLE : WAIT_DRQ;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A strobe already in progress still finishes since cs is decoded
        // from the current state; only the following cycle is cancelled.
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            fetch_d = '0;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fetch_q  <= '0;
            addr_q   <= '0;
            stable_q <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fetch_q  <= fetch_d;
            addr_q   <= addr_d;
            stable_q <= stable_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rom_addr = addr_q;
    assign cs       = (state_q == WRITE);
    assign wrn      = !cs;
    assign dout     = dout_q;

endmodule

// File: doc/jt7759_feeder.md
JT7759_FEEDER -- requirements
Module: jt7759_feeder

Interface
REQ-001 Parameters SHALL be: AW, 17, ROM/byte address width; DEPTH, 4, prefetch buffer entries (power of two, used only with JT7759_FEED_PREFETCH_EN).
REQ-002 clk  input  1  system clock, all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse; begins a transfer.
REQ-005 stop  input  1  one-cycle pulse; aborts the transfer.
REQ-006 start_addr  input  AW  first ROM byte address.
REQ-007 length  input  AW  byte count to transfer.
REQ-008 busy  output  1  transfer in progress.
REQ-009 done  output  1  one-cycle pulse when the last byte has been written.
REQ-010 rom_cs, rom_addr  output  1, AW  ROM request and address.
REQ-011 rom_data, rom_ok  input  8, 1  ROM byte and its valid flag.
REQ-012 drqn  input  1  data request from the slave-mode ADPCM chip, active low.
REQ-013 cs, wrn, dout  output  1, 1, 8  byte write strobe pair and data to the chip.

Function
REQ-014 Write SHALL be cs=1, wrn=0, dout=byte for exactly one clk cycle; otherwise cs=0, wrn=1.
REQ-015 A write SHALL be issued only while busy, a byte is available and drqn is sampled 0.
REQ-016 After each write, drqn SHALL be ignored for 2 clk cycles (holdoff) so the chip's deassertion can propagate.
REQ-017 At most one write SHALL occur per drqn low period; min spacing between writes is 3 cycles.
REQ-018 Write engine states: IDLE, WAIT_DRQ, WRITE, HOLD; IDLE->WAIT_DRQ on accepted start, WAIT_DRQ->WRITE on drqn=0 with byte available, WRITE->HOLD, HOLD->WAIT_DRQ after 2 cycles or ->IDLE when count reaches 0.
REQ-019 A ROM byte SHALL be captured only when rom_cs=1, rom_ok=1 and rom_addr has been unchanged for at least one prior cycle.
REQ-020 rom_addr SHALL increment by 1 after each capture, wrapping from 2^AW-1 to 0.
REQ-021 Remaining-byte counter SHALL load length on start and decrement per write; done pulses the cycle after the write of the last byte, then busy=0.
REQ-022 start with length=0 SHALL produce done in the next cycle, no ROM access, no write.
REQ-023 start while busy SHALL be ignored.
REQ-024 stop SHALL return to IDLE next cycle: busy=0, rom_cs=0, cs=0, buffer flushed, done not pulsed; stop during WRITE still completes that single cycle strobe.
REQ-025 start and stop in the same cycle: stop SHALL win, no transfer starts.
REQ-026 rom_cs SHALL be 0 whenever no capture is needed (buffer full or all bytes fetched).

Reset
REQ-027 On rst: busy=0, done=0, rom_cs=0, rom_addr=0, cs=0, wrn=1, dout=0, counters 0, buffer empty, state IDLE.
REQ-028 rst asserted mid-transfer SHALL abort immediately without a done pulse; after release, the block waits for a new start.

Configuration
REQ-029 Macro JT7759_FEED_PREFETCH_EN defined: a DEPTH-entry FIFO is filled from ROM from the cycle after start, independently of drqn; writes pop the FIFO; fetch stops at full or when length bytes have been fetched.
REQ-030 Macro undefined: single-byte holding register; the ROM fetch for byte n+1 starts only after byte n is written; interface and all other requirements unchanged.

Verification
REQ-031 start_addr=0x1FFFE, length=3, rom_ok always 1, drqn low continuously -> bytes from 0x1FFFE, 0x1FFFF, 0x00000 written, writes 3 cycles apart, done once, busy=0.
REQ-032 length=0 start -> done one cycle later, rom_cs never 1, cs never 1.
REQ-033 length=8, chip model raises drqn 1 cycle after each write and lowers it 20 cycles later -> exactly 8 single-cycle strobes, one per drqn low period, data matches ROM.
REQ-034 rom_ok delayed 5 cycles per access -> no capture before address stable, correct bytes; with PREFETCH_EN the FIFO holds 4 bytes before first drqn low.
REQ-035 stop after 2 of 6 bytes, start in same cycle as stop, and rst mid-transfer -> no further strobes, no done, busy=0, clean restart on next start.
